// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding the decoder. Holds the PC, keeps at most one
//   word-read outstanding to instruction memory, and buffers the responses in a
//   small prefetch FIFO. The FIFO head drives the decoder's IR input. A redirect
//   flushes the FIFO, reloads the PC and discards any response still in flight.
//
// Parameters
//   ADDR_W    width of the PC / instruction memory word address
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  PC loaded on reset
//
// Ports
//   i_clk, i_reset_n   clock (rising edge), asynchronous active-low reset
//   o_imem_req         one-cycle read request strobe
//   o_imem_addr        word address of the request (meaningful while o_imem_req=1)
//   i_imem_ack         one-cycle response strobe, in order, >= 1 cycle after req
//   i_imem_data        instruction word returned with i_imem_ack
//   i_stall            downstream does not accept the FIFO head this cycle
//   i_redirect         flush and restart fetching at i_redirect_pc
//   i_redirect_pc      new fetch address
//   o_ir, o_pc         FIFO head instruction and its address (zero when empty)
//   o_valid            FIFO non-empty
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_data,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [31:0]       o_ir,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FETCH: nothing outstanding; WAIT: one response expected and kept;
  // DROP: one response expected but it belongs to a flushed stream.
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_after_pop;
  logic              fifo_nonempty, pop, push, issue;

  logic [31:0]       fifo_ir [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];

  assign fifo_nonempty = (count != '0);

  // A redirect suppresses both pop and push: the FIFO is being cleared anyway.
  assign pop  = fifo_nonempty && !i_stall && !i_redirect;
  assign push = (state == S_WAIT) && i_imem_ack && !i_redirect;

  // A slot freed by this cycle's pop may be claimed by this cycle's request.
  assign count_after_pop = count - CNT_W'(pop);

  // Reset gates the strobe so no request escapes while the block is held in
  // reset (state already reads FETCH with an empty FIFO).
  assign issue = i_reset_n && (state == S_FETCH) && !i_redirect &&
                 (count_after_pop < CNT_W'(DEPTH));

  assign o_imem_req  = issue;
  assign o_imem_addr = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (issue) state_nxt = S_WAIT;
      // An ack arriving with a redirect closes the request; its data is lost
      // because push is blocked by the redirect.
      S_WAIT: begin
        if (i_imem_ack)      state_nxt = S_FETCH;
        else if (i_redirect) state_nxt = S_DROP;
      end
      S_DROP:  if (i_imem_ack) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (i_redirect) begin
        pc     <= i_redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (issue) begin
          pc     <= pc + ADDR_W'(1);
          req_pc <= pc;
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_after_pop + CNT_W'(push);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only read once count says
  // it was written, so clearing it would buy nothing but reset fan-out.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_ir[wr_ptr] <= i_imem_data;
      fifo_pc[wr_ptr] <= req_pc;
    end
  end

  assign o_valid = fifo_nonempty;
  assign o_ir    = fifo_nonempty ? fifo_ir[rd_ptr] : 32'h0;
  assign o_pc    = fifo_nonempty ? fifo_pc[rd_ptr] : '0;

endmodule
